// File: rtl/magma_ecb_core.sv
// rtl/magma_ecb_core.sv - Magma (GOST R 34.12-2015) engine on two 64-bit blocks, one round per clock
module magma_ecb_core (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         decrypt_i,
    input  logic [127:0] data_in_i,
    input  logic [255:0] key_i,
    output logic [127:0] data_out_o,
    output logic         done_o,
    output logic         busy_o
);

    typedef enum logic {IDLE, RUN} state_t;

    // Nibble v of entry i holds pi_i(v).
    localparam logic [63:0] SBOX [8] = '{
        64'h1F307D8E9B5A264C,
        64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B,
        64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7,
        64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8,
        64'h2BC96AF43850DE71
    };

    function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] sum;
        logic [31:0] sub;
        logic [63:0] row;
        logic [5:0]  idx;
        sum = a + k;
        sub = '0;
        for (int i = 0; i < 8; i++) begin
            row = SBOX[i];
            idx = {sum[4*i +: 4], 2'b00};
            sub[4*i +: 4] = row[idx +: 4];
        end
        return {sub[20:0], sub[31:21]};
    endfunction

    // The final round leaves the halves unswapped.
    function automatic logic [63:0] round_fn(input logic [63:0] blk, input logic [31:0] k,
                                             input logic last);
        logic [31:0] t;
        t = blk[63:32] ^ g_fn(blk[31:0], k);
        return last ? {t, blk[31:0]} : {blk[31:0], t};
    endfunction

    state_t         state_q, state_d;
    logic [4:0]     rnd_q, rnd_d;
    logic [255:0]   key_q, key_d;
    logic           dec_q, dec_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   dout_q, dout_d;
    logic           done_q, done_d;

    logic [2:0]     kidx;
    logic [31:0]    rkey;
    logic           last_rnd;
    logic [127:0]   blk_rnd;

    // Reversed key order is simply the bitwise complement of the 3-bit index.
    always_comb begin
        kidx = rnd_q[2:0];
        if (dec_q) begin
            if (rnd_q >= 5'd8) kidx = ~rnd_q[2:0];
        end else begin
            if (rnd_q >= 5'd24) kidx = ~rnd_q[2:0];
        end
    end

    assign rkey     = key_q[{~kidx, 5'b00000} +: 32];
    assign last_rnd = (rnd_q == 5'd31);
    assign blk_rnd  = {round_fn(blk_q[127:64], rkey, last_rnd),
                       round_fn(blk_q[63:0],   rkey, last_rnd)};

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        dec_d   = dec_q;
        blk_d   = blk_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    rnd_d   = 5'd0;
                    key_d   = key_i;
                    dec_d   = decrypt_i;
                    blk_d   = data_in_i;
                end
            end
            RUN: begin
                blk_d = blk_rnd;
                rnd_d = rnd_q + 5'd1;
                if (last_rnd) begin
                    dout_d  = blk_rnd;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            blk_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            blk_q   <= blk_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign data_out_o = dout_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q == RUN);

endmodule
